// File: rtl/gpu_pkg.sv
// Shared rasterizer types and constants: draw-op record, FSM states,
// screen geometry and the magenta colour key.
package gpu_pkg;

  localparam int HOR_ACTIVE_PIXELS = 640;
  localparam int VER_ACTIVE_PIXELS = 480;
  localparam int FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);
  localparam int SPRITE_ADDR_WIDTH = 16;
  localparam int COLOR_WIDTH       = 12;
  localparam int COORD_WIDTH       = 11;

  localparam logic [COLOR_WIDTH-1:0] TRANSPARENT_COLOR = 12'hF0F;

  typedef struct packed {
    logic [COORD_WIDTH-1:0]       x;
    logic [COORD_WIDTH-1:0]       y;
    logic [COORD_WIDTH-1:0]       width;
    logic [COORD_WIDTH-1:0]       height;
    logic [COLOR_WIDTH-1:0]       color;
    logic                         mem_en;
    logic [SPRITE_ADDR_WIDTH-1:0] mem_addr;
    logic                         scale;
  } gpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } gpu_state_t;

  // Starting row base for a rectangle; a constant-coefficient product
  // evaluated once per op, the per-row stepping is purely additive.
  function automatic logic [FB_ADDR_WIDTH-1:0] row_offset(input logic [COORD_WIDTH-1:0] y);
    return FB_ADDR_WIDTH'(y) * FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
  endfunction

endpackage

// File: rtl/gpu_rasterizer_if.sv
// Op handshake, sprite ROM and framebuffer write bus of the rasterizer.
// master: cpu/memory side, slave: the rasterizer.
interface gpu_rasterizer_if;
  import gpu_pkg::*;

  gpu_op_t                      op;
  logic                         op_valid;
  logic                         op_ready;
  logic [SPRITE_ADDR_WIDTH-1:0] rom_addr;
  logic [COLOR_WIDTH-1:0]       rom_data;
  logic [FB_ADDR_WIDTH-1:0]     fb_addr;
  logic [COLOR_WIDTH-1:0]       fb_data;
  logic                         fb_we;

  modport master (
    output op, op_valid, rom_data,
    input  op_ready, rom_addr, fb_addr, fb_data, fb_we
  );

  modport slave (
    input  op, op_valid, rom_data,
    output op_ready, rom_addr, fb_addr, fb_data, fb_we
  );

endinterface

// File: rtl/gpu_raster_scan.sv
// Raster walker: dx/dy counters, framebuffer row base and sprite row base
// accumulators. Holds on the last pixel so rom_addr stays stable afterwards.
module gpu_raster_scan
  import gpu_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         step,
  input  logic [COORD_WIDTH-1:0]       op_x,
  input  logic [COORD_WIDTH-1:0]       op_y,
  input  logic [COORD_WIDTH-1:0]       op_w,
  input  logic [COORD_WIDTH-1:0]       op_h,
  input  logic                         op_scale,
  input  logic [SPRITE_ADDR_WIDTH-1:0] op_mem_addr,
  output logic [COORD_WIDTH:0]         px,
  output logic [COORD_WIDTH:0]         py,
  output logic [FB_ADDR_WIDTH-1:0]     pix_addr,
  output logic [SPRITE_ADDR_WIDTH-1:0] rom_addr,
  output logic                         last
);

  logic [COORD_WIDTH-1:0]       x, y, w, h, stride, dx, dy;
  logic                         scale;
  logic [FB_ADDR_WIDTH-1:0]     row_base;
  logic [SPRITE_ADDR_WIDTH-1:0] srow;
  logic                         row_end;

  assign row_end = (dx == w - 11'd1);

  // Load op geometry on start, then walk dx inner / dy outer one pixel per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      w        <= '0;
      h        <= '0;
      scale    <= 1'b0;
      stride   <= '0;
      dx       <= '0;
      dy       <= '0;
      row_base <= '0;
      srow     <= '0;
    end else if (start) begin
      x        <= op_x;
      y        <= op_y;
      w        <= op_w;
      h        <= op_h;
      scale    <= op_scale;
      stride   <= op_w >> op_scale;
      dx       <= '0;
      dy       <= '0;
      row_base <= row_offset(op_y);
      srow     <= op_mem_addr;
    end else if (step) begin
      if (row_end) begin
        dx       <= '0;
        dy       <= dy + 11'd1;
        row_base <= row_base + FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
        // With 2x upscale each sprite row is shown twice, so advance every other row.
        if (!scale || dy[0]) srow <= srow + {5'b0, stride};
      end else begin
        dx <= dx + 11'd1;
      end
    end
  end

  assign px       = {1'b0, x} + {1'b0, dx};
  assign py       = {1'b0, y} + {1'b0, dy};
  assign pix_addr = row_base + FB_ADDR_WIDTH'(px);
  assign rom_addr = srow + {5'b0, (dx >> scale)};
  assign last     = row_end && (dy == h - 11'd1);

endmodule

// File: rtl/gpu_rasterizer.sv
// Draw-op rasterizer: handshake FSM, clipping and the 2-stage output pipeline
// feeding the back framebuffer. Optional macro GPU_TRANSPARENCY_EN suppresses
// writes of magenta-keyed sprite texels.
module gpu_rasterizer
  import gpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  gpu_rasterizer_if.slave bus
);

  gpu_state_t             state;
  logic                   drain_cnt;
  logic [COLOR_WIDTH-1:0] op_color;
  logic                   op_mem_en;

  logic                     accept, nonzero, start, step, keyed;
  logic [COORD_WIDTH:0]     px, py;
  logic [FB_ADDR_WIDTH-1:0] pix_addr;
  logic                     last;

  logic                     s1_valid, s1_clip;
  logic [FB_ADDR_WIDTH-1:0] s1_addr;

  assign accept  = bus.op_valid && bus.op_ready;
  assign nonzero = (bus.op.width != '0) && (bus.op.height != '0);
  assign start   = accept && nonzero;
  assign step    = (state == ST_SCAN) && !last;

  gpu_raster_scan u_scan (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step       (step),
    .op_x       (bus.op.x),
    .op_y       (bus.op.y),
    .op_w       (bus.op.width),
    .op_h       (bus.op.height),
    .op_scale   (bus.op.scale),
    .op_mem_addr(bus.op.mem_addr),
    .px         (px),
    .py         (py),
    .pix_addr   (pix_addr),
    .rom_addr   (bus.rom_addr),
    .last       (last)
  );

  // Handshake FSM; drain_cnt covers the two pipeline stages after the last slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.op_ready <= 1'b1;
      drain_cnt    <= 1'b0;
      op_color     <= '0;
      op_mem_en    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_color     <= bus.op.color;
          op_mem_en    <= bus.op.mem_en;
          bus.op_ready <= 1'b0;
          drain_cnt    <= 1'b1;
          state        <= nonzero ? ST_SCAN : ST_DRAIN;
        end
        ST_SCAN: if (last) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (drain_cnt == 1'b0) begin
            state        <= ST_IDLE;
            bus.op_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: issue slot, clip flag and target address; ROM read is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_clip  <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= (state == ST_SCAN);
      s1_clip  <= (px >= 12'(HOR_ACTIVE_PIXELS)) || (py >= 12'(VER_ACTIVE_PIXELS));
      s1_addr  <= pix_addr;
    end
  end

`ifdef GPU_TRANSPARENCY_EN
  assign keyed = op_mem_en && (bus.rom_data == TRANSPARENT_COLOR);
`else
  assign keyed = 1'b0;
`endif

  // Stage 2: framebuffer address, data and strobe registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_data <= '0;
    end else begin
      bus.fb_we <= s1_valid && !s1_clip && !keyed;
      if (s1_valid) begin
        bus.fb_addr <= s1_addr;
        bus.fb_data <= op_mem_en ? bus.rom_data : op_color;
      end
    end
  end

endmodule

// File: tb/tb_gpu_rasterizer.sv
// Directed bench for gpu_rasterizer with a synchronous sprite ROM model and
// a framebuffer write logger.
module tb_gpu_rasterizer;
  import gpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpu_rasterizer_if bus();

  gpu_rasterizer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    if (a == 16'd500) return 12'hF0F;
    if (a == 16'd501) return 12'h123;
    return a[11:0] * 12'd7 + 12'd3;
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  logic [18:0] wr_addr[$];
  logic [11:0] wr_data[$];
  always @(negedge clk) begin
    if (bus.fb_we === 1'b1) begin
      wr_addr.push_back(bus.fb_addr);
      wr_data.push_back(bus.fb_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic gpu_op_t make_op(input int x, input int y, input int w, input int h,
                                      input int color, input bit mem_en, input int mem_addr,
                                      input bit scale);
    gpu_op_t o;
    o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
    o.color = 12'(color); o.mem_en = mem_en; o.mem_addr = 16'(mem_addr); o.scale = scale;
    return o;
  endfunction

  task automatic send_op(input gpu_op_t o);
    @(negedge clk);
    bus.op = o;
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      cycles++;
      #1;
      if (bus.op_ready) break;
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  int cyc;
  int bad;
  int exp_rom[16]  = '{100,100,101,101, 100,100,101,101, 102,102,103,103, 102,102,103,103};
  int exp_fb[16]   = '{6420,6421,6422,6423, 7060,7061,7062,7063,
                       7700,7701,7702,7703, 8340,8341,8342,8343};

  initial begin
    bus.op = '0;
    bus.op_valid = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_fb_data", bus.fb_data, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1x1 solid: first write exactly two cycles after accept
    clear_log();
    send_op(make_op(5, 2, 1, 1, 12'h777, 1'b0, 0, 1'b0));
    @(negedge clk); @(negedge clk);
    chk("lat_e1_we", bus.fb_we, 0);
    @(negedge clk);
    chk("lat_e2_we", bus.fb_we, 1);
    chk("lat_e2_addr", bus.fb_addr, 1285);
    chk("lat_e2_data", bus.fb_data, 12'h777);
    chk("lat_e2_ready", bus.op_ready, 0);
    @(negedge clk);
    chk("lat_e3_ready", bus.op_ready, 1);
    chk("lat_e3_we", bus.fb_we, 0);

    // Full-width solid band 640x4 at origin
    clear_log();
    send_op(make_op(0, 0, 640, 4, 12'h0AB, 1'b0, 0, 1'b0));
    wait_ready(3000, cyc);
    chk("band_latency", cyc, 2562);
    chk("band_writes", wr_addr.size(), 2560);
    bad = 0;
    foreach (wr_addr[i]) if (wr_addr[i] !== 19'(i) || wr_data[i] !== 12'h0AB) bad++;
    chk("band_seq", bad, 0);

    // Bottom-right clipping
    clear_log();
    send_op(make_op(638, 478, 4, 4, 12'h0F0, 1'b0, 0, 1'b0));
    wait_ready(100, cyc);
    chk("clip_latency", cyc, 18);
    chk("clip_writes", wr_addr.size(), 4);
    if (wr_addr.size() == 4) begin
      chk("clip_a0", wr_addr[0], 306558);
      chk("clip_a1", wr_addr[1], 306559);
      chk("clip_a2", wr_addr[2], 307198);
      chk("clip_a3", wr_addr[3], 307199);
      chk("clip_d3", wr_data[3], 12'h0F0);
    end

    // 4x4 sprite, 2x upscale
    clear_log();
    send_op(make_op(20, 10, 4, 4, 12'hFFF, 1'b1, 100, 1'b1));
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("spr_rom%0d", i), bus.rom_addr, exp_rom[i]);
      @(posedge clk);
      #1;
    end
    wait_ready(20, cyc);
    chk("spr_tail", cyc, 2);
    chk("spr_writes", wr_addr.size(), 16);
    if (wr_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("spr_fa%0d", i), wr_addr[i], exp_fb[i]);
        chk($sformatf("spr_fd%0d", i), wr_data[i], rom_fn(16'(exp_rom[i])));
      end
    end

    // Zero-width op; op_valid held high while busy
    clear_log();
    @(negedge clk);
    bus.op = make_op(0, 0, 0, 50, 12'h111, 1'b1, 900, 1'b0);
    bus.op_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.op = make_op(0, 0, 2, 2, 12'h222, 1'b0, 0, 1'b0);
    chk("zero_e0_ready", bus.op_ready, 0);
    @(posedge clk);
    #1;
    chk("zero_e1_ready", bus.op_ready, 0);
    @(posedge clk);
    #1;
    chk("zero_e2_ready", bus.op_ready, 1);
    bus.op_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("zero_writes", wr_addr.size(), 0);
    chk("zero_rom_addr", bus.rom_addr, 103);
    chk("zero_idle_ready", bus.op_ready, 1);

    // Async reset in the middle of a 40x200 op
    send_op(make_op(0, 0, 40, 200, 12'h321, 1'b0, 0, 1'b0));
    repeat (100) @(posedge clk);
    #1;
    chk("mid_we_before", bus.fb_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", bus.fb_we, 0);
    chk("mid_rst_ready", bus.op_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_op(make_op(1, 1, 3, 1, 12'h456, 1'b0, 0, 1'b0));
    wait_ready(50, cyc);
    chk("post_latency", cyc, 5);
    chk("post_writes", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      chk("post_a0", wr_addr[0], 641);
      chk("post_a2", wr_addr[2], 643);
      chk("post_d0", wr_data[0], 12'h456);
    end

    // Magenta key on a 2x1 sprite
    clear_log();
    send_op(make_op(30, 5, 2, 1, 12'h000, 1'b1, 500, 1'b0));
    wait_ready(50, cyc);
    chk("key_latency", cyc, 4);
`ifdef GPU_TRANSPARENCY_EN
    chk("key_writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("key_a0", wr_addr[0], 3231);
      chk("key_d0", wr_data[0], 12'h123);
    end
`else
    chk("key_writes", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("key_a0", wr_addr[0], 3230);
      chk("key_d0", wr_data[0], 12'hF0F);
      chk("key_a1", wr_addr[1], 3231);
      chk("key_d1", wr_data[1], 12'h123);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
